display_bcd_ctrl: RTL and testbench
===================================

# display_bcd_ctrl

Sequencing controller in front of the 4-digit multiplexed seven-segment driver. It accepts a binary result (e.g. the adder sum) over a valid/ready handshake and converts it to packed 4-digit BCD with an iterative shift-add-3 (double-dabble) FSM. It then loads the result into a held register that drives the display's 16-bit BCD input. Out-of-range values set an overflow flag and are shown fully blank; the display never sees intermediate conversion state.

## Interface
- BIN_WIDTH, 14, width of binary input; legal range 14..16
- clk  in  1  system clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- bin_i  in  BIN_WIDTH  unsigned binary value to display
- valid_i  in  1  bin_i valid; transfer on valid_i && ready_o at rising clk
- ready_o  out  1  controller idle, able to accept
- bcd_o  out  16  packed BCD to display; [3:0] units … [15:12] thousands
- done_o  out  1  one-cycle pulse when bcd_o/ovf_o have just been updated
- ovf_o  out  1  last accepted value exceeded 9999; held until next update

## Operation
- States: IDLE, SHIFT, DONE. ready_o = (state == IDLE), combinational from state.
- IDLE: on handshake, capture bin_i into a shift register and clear the 16-bit BCD scratch and the iteration counter.
  - bin_i > 9999: latch ovf, go to DONE directly.
  - Otherwise go to SHIFT.
- SHIFT: each cycle, add 3 to every scratch nibble ≥ 5, then shift {scratch, bin} left by 1.
  - Counter counts BIN_WIDTH shifts. After the last one, go to DONE.
- DONE: one cycle, then IDLE. On the DONE→IDLE edge:
  - bcd_o ← result (after optional blanking), or 16'hFFFF if ovf.
  - ovf_o ← ovf.
  - done_o ← 1 for exactly one cycle.
- bcd_o and ovf_o change only on that edge. They hold their previous values for the whole conversion, so there is no display flicker.
- valid_i while ready_o = 0 is ignored. No queuing; the requester must hold valid_i until the transfer.
- Nibble 4'hF is the display driver's "all segments off" code.

## Timing
- Reset (rst_i = 1, asynchronous): state IDLE, ready_o = 1, done_o = 0, ovf_o = 0.
  - bcd_o = 16'h0000 without macro, 16'hFFF0 with macro.
  - Scratch and counter cleared.
- Normal conversion, handshake at edge E0:
  - SHIFT on edges E1..E(BIN_WIDTH); at BIN_WIDTH = 14 the last shift is E14, entering DONE.
  - bcd_o and done_o update at E(BIN_WIDTH+1), i.e. E15 at default.
  - ready_o is low from after E0 until after E(BIN_WIDTH+1).
- Overflow path: handshake at E0 → DONE; outputs update at E1.
- ready_o is high in the same cycle done_o is high, so back-to-back accept is possible.
  - Minimum accept-to-accept spacing: BIN_WIDTH+2 cycles (normal), 2 cycles (overflow).
- Boundary values: 9999 converts normally; 10000 takes the overflow path. BIN_WIDTH = 16 with 16'hFFFF → overflow.
- Reset mid-conversion aborts immediately. bcd_o returns to its reset value and no done_o is produced.

## Configuration
- DISPLAY_LEADING_ZERO_BLANK_EN defined:
  - Digits 3, 2 and 1 are replaced by 4'hF when that digit and all higher digits are zero.
  - Digit 0 is never blanked.
  - Applied only when loading bcd_o; the overflow value is unaffected.
- Undefined: bcd_o always carries all four BCD digits, leading zeros included.

## Structure
- Shared package display_pkg:
  - state typedef (IDLE/SHIFT/DONE).
  - MAX_BCD_VALUE = 9999.
  - BLANK_NIBBLE = 4'hF.
  - NUM_DIGITS = 4.
  - BCD_WIDTH = 16.
- Sub-module bcd_add3: combinational 4-bit "≥5 → +3" correction, instantiated once per digit inside the SHIFT datapath.
- Counter width: $clog2(BIN_WIDTH+1).

## Test plan
- Reset, then idle: ready_o = 1, bcd_o = 16'h0000 (16'hFFF0 with macro), done_o = 0, ovf_o = 0.
- Send 1234: ready_o drops for 15 cycles; done_o pulses 15 cycles after the handshake edge; bcd_o = 16'h1234, ovf_o = 0.
- Send 9999, then 10000 in the done_o cycle:
  - First gives bcd_o = 16'h9999.
  - Second is accepted immediately; 1 cycle later bcd_o = 16'hFFFF, ovf_o = 1.
- Macro on, send 0, 42, 1005: bcd_o = 16'hFFF0, 16'hFF42, 16'h1005.
- Send 5678 then pulse valid_i with 1111 at cycle 5 of the conversion: 1111 is ignored and bcd_o = 16'h5678.
- Send 4321, assert rst_i at cycle 7 of the conversion: no done_o, bcd_o = reset value, ready_o = 1 after release.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the BCD display controller.
// Latency: n/a (package). Backpressure: n/a.
// Leading-zero blanking helper is used only when DISPLAY_LEADING_ZERO_BLANK_EN is defined.
package display_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    localparam int unsigned MAX_BCD_VALUE = 9999;
    localparam logic [3:0]  BLANK_NIBBLE  = 4'hF;
    localparam int          NUM_DIGITS    = 4;
    localparam int          BCD_WIDTH     = 16;

    // Blank digits 3..1 while they and every higher digit are zero; digit 0 always shows.
    function automatic logic [BCD_WIDTH-1:0] blank_leading_zeros(input logic [BCD_WIDTH-1:0] bcd);
        logic [BCD_WIDTH-1:0] r;
        logic                 lead;
        r    = bcd;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (lead && bcd[i*4 +: 4] == 4'd0) begin
                r[i*4 +: 4] = BLANK_NIBBLE;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: nibbles of 5 or more get +3 before the shift.
// Latency: combinational. Backpressure: none.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/display_bcd_ctrl.sv
// Binary-to-BCD sequencer feeding the 4-digit display; shows 16'hFFFF on values above 9999.
// Latency: BIN_WIDTH+1 cycles accept-to-done (1 cycle on overflow). Backpressure: ready_o low while busy.
// Optional DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zero digits when loading bcd_o.
module display_bcd_ctrl
    import display_pkg::*;
#(
    parameter int BIN_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic [BIN_WIDTH-1:0] bin_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [15:0]          bcd_o,
    output logic                 done_o,
    output logic                 ovf_o
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    localparam logic [BCD_WIDTH-1:0] RST_BCD = 16'hFFF0;
`else
    localparam logic [BCD_WIDTH-1:0] RST_BCD = 16'h0000;
`endif

    state_t                           state;
    logic [BIN_WIDTH-1:0]             bin_sr;
    logic [BCD_WIDTH-1:0]             scratch;
    logic [BCD_WIDTH-1:0]             corrected;
    logic [BCD_WIDTH-1:0]             result;
    logic [BCD_WIDTH+BIN_WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]                 cnt;
    logic                             ovf_r;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .d (scratch[g*4 +: 4]),
            .q (corrected[g*4 +: 4])
        );
    end

    assign shifted = {corrected, bin_sr} << 1;

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    assign result = blank_leading_zeros(scratch);
`else
    assign result = scratch;
`endif

    assign ready_o = (state == IDLE);

    // bcd_o/ovf_o load only on the DONE->IDLE edge so the display never sees scratch state.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            ovf_r   <= 1'b0;
            bcd_o   <= RST_BCD;
            ovf_o   <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        bin_sr  <= bin_i;
                        scratch <= '0;
                        cnt     <= '0;
                        if (bin_i > BIN_WIDTH'(MAX_BCD_VALUE)) begin
                            ovf_r <= 1'b1;
                            state <= DONE;
                        end else begin
                            ovf_r <= 1'b0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    scratch <= shifted[BCD_WIDTH+BIN_WIDTH-1:BIN_WIDTH];
                    bin_sr  <= shifted[BIN_WIDTH-1:0];
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd_o  <= ovf_r ? {BCD_WIDTH{1'b1}} : result;
                    ovf_o  <= ovf_r;
                    done_o <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_bcd_ctrl.sv
// Randomized bench for display_bcd_ctrl against a decimal-arithmetic reference model.
module tb_display_bcd_ctrl;

    localparam int BW = 14;

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    localparam logic [15:0] RST_BCD = 16'hFFF0;
`else
    localparam logic [15:0] RST_BCD = 16'h0000;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [BW-1:0] bin_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [15:0]   bcd_o;
    logic          done_o;
    logic          ovf_o;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [15:0]   shown = RST_BCD;
    logic          shown_ovf = 1'b0;

    display_bcd_ctrl #(.BIN_WIDTH(BW)) dut (
        .clk     (clk),
        .rst_i   (rst_i),
        .bin_i   (bin_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .bcd_o   (bcd_o),
        .done_o  (done_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by division; digit i>0 is blank iff the value is below 10^i.
    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        int          d;
        int          p;
        if (v > 9999) return 16'hFFFF;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            d = (v / p) % 10;
            r[i*4 +: 4] = d[3:0];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
            if (i > 0 && v < p) r[i*4 +: 4] = 4'hF;
`endif
            p = p * 10;
        end
        return r;
    endfunction

    // poke_cycle: -1 none, 0 random pokes every busy cycle, k>0 a single poke k cycles after accept.
    task automatic xfer(input int v, input int poke_cycle, input int poke_val);
        int          lat = 0;
        int          w = 0;
        bit          seen = 1'b0;
        bit          hold_ok = 1'b1;
        bit          busy_ok = 1'b1;
        bit          do_poke;
        int          exp_lat;
        logic [15:0] eb;
        exp_lat = (v > 9999) ? 1 : BW + 1;
        eb      = model_bcd(v);
        @(negedge clk);
        valid_i = 1'b1;
        bin_i   = BW'(v);
        while (!ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", 32'(w < 50), 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
            if (bcd_o !== shown || ovf_o !== shown_ovf) hold_ok = 1'b0;
            if (ready_o) busy_ok = 1'b0;
            do_poke = (poke_cycle == 0) ? ($urandom_range(0, 1) == 1) : (k == poke_cycle);
            valid_i = do_poke;
            bin_i   = BW'((poke_cycle == 0) ? $urandom_range(0, (1 << BW) - 1) : poke_val);
        end
        valid_i = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("bcd", 32'(bcd_o), 32'(eb));
        check("ovf", 32'(ovf_o), 32'(v > 9999));
        check("ready_in_done", 32'(ready_o), 32'd1);
        check("hold_during_conv", 32'(hold_ok), 32'd1);
        check("busy_ready_low", 32'(busy_ok), 32'd1);
        shown     = eb;
        shown_ovf = (v > 9999);
    endtask

    task automatic xfer_abort(input int v, input int rst_cycle);
        bit no_done = 1'b1;
        @(negedge clk);
        valid_i = 1'b1;
        bin_i   = BW'(v);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (rst_cycle) @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        check("abort_bcd", 32'(bcd_o), 32'(RST_BCD));
        check("abort_ovf", 32'(ovf_o), 32'd0);
        check("abort_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done_o) no_done = 1'b0;
        end
        check("abort_no_done", 32'(no_done), 32'd1);
        check("abort_ready_after", 32'(ready_o), 32'd1);
        check("abort_bcd_after", 32'(bcd_o), 32'(RST_BCD));
        shown     = RST_BCD;
        shown_ovf = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bcd_in_reset", 32'(bcd_o), 32'(RST_BCD));
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_bcd", 32'(bcd_o), 32'(RST_BCD));
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);

        xfer(1234, -1, 0);
        xfer(9999, -1, 0);
        xfer(10000, -1, 0);
        xfer(0, -1, 0);
        xfer(42, -1, 0);
        xfer(1005, -1, 0);
        xfer(5678, 5, 1111);
        xfer_abort(4321, 7);
        xfer(1, -1, 0);
        xfer((1 << BW) - 1, -1, 0);
        xfer(7, -1, 0);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, (1 << BW) - 1));
            else                           v = int'($urandom_range(0, 9999));
            xfer(v, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
